ring_switch_alloc3: RTL and testbench

RING_SWITCH_ALLOC3 -- requirements
Module: ring_switch_alloc3

---
 rtl/ring_switch_alloc3_pkg.sv | 23 ++
 rtl/ring_switch_alloc3_if.sv | 45 ++++
 rtl/ring_switch_alloc3_vc_RRArb3.sv | 61 ++++++
 rtl/ring_switch_alloc3.sv | 124 ++++++++++++
 tb/tb_ring_switch_alloc3.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_switch_alloc3_pkg.sv
// Shared ring-network definitions for the 3x3 single-flit switch allocator:
// port count, select/destination encoding, the invalid-destination code and
// the priority pointer reset value.
package ring_switch_alloc3_pkg;

  // Fixed radix: 3 inputs x 3 outputs.
  localparam int NUM_PORTS = 3;

  // Select / destination encoding: value k names port k (0..2).
  typedef logic [1:0] port_idx_t;

  // Destination code that never maps to an output; such packets are dropped.
  localparam port_idx_t DEST_INVALID = 2'd3;

  // Round-robin pointer value after reset: input 0 is looked at first.
  localparam port_idx_t PRIO_RESET = 2'd0;

  // Next port in ring order, wrapping 2 -> 0.
  function automatic port_idx_t next_port(input port_idx_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/ring_switch_alloc3_if.sv
// Handshake and control bundle between the traffic sources/sinks and the
// ring_switch_alloc3 allocator. master = environment side, slave = allocator.
//
// Handshake semantics (both sides): a packet moves on a rising clk edge when
// its valid and its ready are both high in the cycle before that edge. A
// source holding valid must keep its packet, destination and domain stable
// until it sees ready; ready may depend combinationally on valid/dest.
// in_val/in_rdy form the input side; out_val/out_rdy form the output side.
interface ring_switch_alloc3_if;

  logic [2:0] in_val;
  logic [1:0] in_dest0;
  logic [1:0] in_dest1;
  logic [1:0] in_dest2;
  logic       in_domain0;
  logic       in_domain1;
  logic       in_domain2;
  logic [2:0] in_rdy;

  logic       out0_domain;
  logic       out1_domain;
  logic       out2_domain;
  logic [2:0] out_rdy;
  logic [2:0] out_val;
  logic [1:0] sel0;
  logic [1:0] sel1;
  logic [1:0] sel2;

  logic [2:0] drop_bad_dest;

  modport master (
    output in_val, in_dest0, in_dest1, in_dest2,
    output in_domain0, in_domain1, in_domain2,
    output out0_domain, out1_domain, out2_domain, out_rdy,
    input  in_rdy, out_val, sel0, sel1, sel2, drop_bad_dest
  );

  modport slave (
    input  in_val, in_dest0, in_dest1, in_dest2,
    input  in_domain0, in_domain1, in_domain2,
    input  out0_domain, out1_domain, out2_domain, out_rdy,
    output in_rdy, out_val, sel0, sel1, sel2, drop_bad_dest
  );

endinterface

// File: rtl/ring_switch_alloc3_vc_RRArb3.sv
// vc_RRArb3: 3-requester round-robin arbiter. The priority pointer names the
// requester checked first; after a grant it moves to the one after the winner.
// With i_en low no grant is issued and the pointer holds.
module vc_RRArb3
  import ring_switch_alloc3_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_en,
  input  logic [2:0] i_req,
  output logic [2:0] o_gnt,
  output port_idx_t o_gnt_idx,
  output logic      o_any,
  output port_idx_t o_prio
);

  port_idx_t r_prio;
  port_idx_t w_prio_nxt;
  port_idx_t w_c0;
  port_idx_t w_c1;
  port_idx_t w_c2;
  logic [3:0] w_req4;
  port_idx_t w_idx;
  logic      w_any;

  assign w_c0   = r_prio;
  assign w_c1   = next_port(w_c0);
  assign w_c2   = next_port(w_c1);
  assign w_req4 = {1'b0, i_req};

  // Pick the first requester in ring order starting at the pointer.
  always_comb begin
    w_any = 1'b0;
    w_idx = r_prio;
    if (i_en) begin
      if (w_req4[w_c0]) begin
        w_any = 1'b1;
        w_idx = w_c0;
      end else if (w_req4[w_c1]) begin
        w_any = 1'b1;
        w_idx = w_c1;
      end else if (w_req4[w_c2]) begin
        w_any = 1'b1;
        w_idx = w_c2;
      end
    end
    w_prio_nxt = w_any ? next_port(w_idx) : r_prio;
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prio <= PRIO_RESET;
    else       r_prio <= w_prio_nxt;
  end

  assign o_gnt     = {w_any & (w_idx == 2'd2), w_any & (w_idx == 2'd1), w_any & (w_idx == 2'd0)};
  assign o_gnt_idx = w_idx;
  assign o_any     = w_any;
  assign o_prio    = r_prio;

endmodule

// File: rtl/ring_switch_alloc3.sv
// ring_switch_alloc3: switch allocator for a 3x3 single-flit ring crossbar.
// Each output owns a round-robin arbiter; a granted input is routed by a
// registered select one cycle later. Packets with destination 3 are consumed
// and reported on drop_bad_dest. No datapath lives here.
// Optional feature macro: RING_SWITCH_ALLOC_DOMAIN_CHECK_EN -- when defined an
// input may only be granted to an output of the same security domain.
module ring_switch_alloc3
  import ring_switch_alloc3_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  ring_switch_alloc3_if.slave  bus,
  output logic [5:0]           o_dbg_prio
);

  port_idx_t             w_dest     [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_in_dom;
  logic [NUM_PORTS-1:0]  w_out_dom;
  logic [NUM_PORTS-1:0]  w_dom_ok   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_req      [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_gnt      [NUM_PORTS];
  port_idx_t             w_gnt_idx  [NUM_PORTS];
  port_idx_t             w_prio     [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_any;
  logic [NUM_PORTS-1:0]  w_free;
  logic [NUM_PORTS-1:0]  w_bad;
  logic [NUM_PORTS-1:0]  w_in_rdy;

  logic [NUM_PORTS-1:0]  r_out_val;
  port_idx_t             r_sel      [NUM_PORTS];
  logic [NUM_PORTS-1:0]  r_drop;

  assign w_dest[0] = bus.in_dest0;
  assign w_dest[1] = bus.in_dest1;
  assign w_dest[2] = bus.in_dest2;
  assign w_in_dom  = {bus.in_domain2, bus.in_domain1, bus.in_domain0};
  assign w_out_dom = {bus.out2_domain, bus.out1_domain, bus.out0_domain};

`ifdef RING_SWITCH_ALLOC_DOMAIN_CHECK_EN
  // Input i may target output j only inside the same security domain.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dom_ok[i] = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        w_dom_ok[i][j] = (w_in_dom[i] == w_out_dom[j]);
      end
    end
  end
`else
  logic w_unused_dom;
  assign w_unused_dom = ^{w_in_dom, w_out_dom};

  // Domain checking disabled: every input may target every output.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dom_ok[i] = '1;
    end
  end
`endif

  // Request matrix, one requester vector per output; dest 3 matches none.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_req[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req[j][i] = bus.in_val[i] & (w_dest[i] == port_idx_t'(j)) & w_dom_ok[i][j];
      end
    end
  end

  // An output can take a new packet when empty or draining this cycle.
  assign w_free = ~r_out_val | bus.out_rdy;

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_arb
    vc_RRArb3 u_arb (
      .clk       (clk),
      .reset     (reset),
      .i_en      (w_free[j] & ~reset),
      .i_req     (w_req[j]),
      .o_gnt     (w_gnt[j]),
      .o_gnt_idx (w_gnt_idx[j]),
      .o_any     (w_any[j]),
      .o_prio    (w_prio[j])
    );
  end

  // Input ready: granted somewhere, or carrying an undeliverable dest.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_bad[i] = bus.in_val[i] & (w_dest[i] == DEST_INVALID);
    end
    w_in_rdy = w_bad;
    for (int j = 0; j < NUM_PORTS; j++) begin
      w_in_rdy = w_in_rdy | w_gnt[j];
    end
    if (reset) w_in_rdy = '0;
  end

  // Output valid/select registers and the drop pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_val <= '0;
      r_drop    <= '0;
      for (int j = 0; j < NUM_PORTS; j++) r_sel[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (w_free[j]) begin
          r_out_val[j] <= w_any[j];
          if (w_any[j]) r_sel[j] <= w_gnt_idx[j];
        end
      end
      r_drop <= w_bad;
    end
  end

  assign bus.in_rdy        = w_in_rdy;
  assign bus.out_val       = r_out_val;
  assign bus.sel0          = r_sel[0];
  assign bus.sel1          = r_sel[1];
  assign bus.sel2          = r_sel[2];
  assign bus.drop_bad_dest = r_drop;
  assign o_dbg_prio        = {w_prio[2], w_prio[1], w_prio[0]};

endmodule

// File: tb/tb_ring_switch_alloc3.sv
// Self-checking bench for ring_switch_alloc3: directed scenarios with literal
// expectations followed by randomized traffic, all cross-checked against a
// cycle-level behavioural model of the allocation rules.
module tb_ring_switch_alloc3;

  logic       clk;
  logic       reset;
  logic [5:0] dbg_prio;

  ring_switch_alloc3_if bus();

  ring_switch_alloc3 dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_prio (dbg_prio)
  );

`ifdef RING_SWITCH_ALLOC_DOMAIN_CHECK_EN
  localparam bit DOM_EN = 1'b1;
`else
  localparam bit DOM_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  // {out_val[3], sel2, sel1, sel0, drop[3], prio2, prio1, prio0}
  logic [17:0] exp_q[$];
  int          m_prio [3];
  int          m_sel  [3];
  bit          m_val  [3];
  logic [2:0]  exp_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dest_of(input int i);
    case (i)
      0: return int'(bus.in_dest0);
      1: return int'(bus.in_dest1);
      default: return int'(bus.in_dest2);
    endcase
  endfunction

  function automatic bit dom_ok(input int i, input int j);
    bit di, dj;
    if (!DOM_EN) return 1'b1;
    di = (i == 0) ? bus.in_domain0 : (i == 1) ? bus.in_domain1 : bus.in_domain2;
    dj = (j == 0) ? bus.out0_domain : (j == 1) ? bus.out1_domain : bus.out2_domain;
    return di == dj;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int i, input bit v, input logic [1:0] d, input bit dom);
    bus.in_val[i] = v;
    case (i)
      0: begin bus.in_dest0 = d; bus.in_domain0 = dom; end
      1: begin bus.in_dest1 = d; bus.in_domain1 = dom; end
      default: begin bus.in_dest2 = d; bus.in_domain2 = dom; end
    endcase
  endtask

  // New packet only where the previous one was taken (or none was offered).
  task automatic rand_inputs();
    for (int i = 0; i < 3; i++) begin
      if (!bus.in_val[i] || exp_rdy[i]) begin
        set_in(i, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
      end
    end
    for (int j = 0; j < 3; j++) bus.out_rdy[j] = $urandom_range(0, 3) != 0;
    if ($urandom_range(0, 7) == 0) bus.out0_domain = ~bus.out0_domain;
    if ($urandom_range(0, 7) == 0) bus.out1_domain = ~bus.out1_domain;
    if ($urandom_range(0, 7) == 0) bus.out2_domain = ~bus.out2_domain;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_prio[j] = 0; m_sel[j] = 0; m_val[j] = 1'b0;
    end
    exp_q.delete();
  endtask

  // ---------------- behavioural model ----------------
  // Settle inputs, predict who is accepted this cycle and what the registered
  // outputs must show after the next edge.
  task automatic settle();
    logic [2:0] nv, nd;
    int ns [3];
    int np [3];
    int g, c;
    bit free;
    #1;
    exp_rdy = '0;
    nv = '0;
    nd = '0;
    for (int j = 0; j < 3; j++) begin
      free = !m_val[j] || bus.out_rdy[j];
      g = -1;
      if (free) begin
        for (int k = 0; k < 3; k++) begin
          c = (m_prio[j] + k) % 3;
          if (g < 0 && bus.in_val[c] && dest_of(c) == j && dom_ok(c, j)) g = c;
        end
      end
      if (!free) begin
        nv[j] = m_val[j]; ns[j] = m_sel[j]; np[j] = m_prio[j];
      end else if (g >= 0) begin
        nv[j] = 1'b1; ns[j] = g; np[j] = (g + 1) % 3;
        exp_rdy[g] = 1'b1;
      end else begin
        nv[j] = 1'b0; ns[j] = m_sel[j]; np[j] = m_prio[j];
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (bus.in_val[i] && dest_of(i) == 3) begin
        nd[i] = 1'b1;
        exp_rdy[i] = 1'b1;
      end
    end
    if (reset) begin
      exp_rdy = '0; nv = '0; nd = '0;
      for (int j = 0; j < 3; j++) begin ns[j] = 0; np[j] = 0; end
    end
    chk("in_rdy", 32'(bus.in_rdy), 32'(exp_rdy));
    exp_q.push_back({nv, 2'(ns[2]), 2'(ns[1]), 2'(ns[0]), nd,
                     2'(np[2]), 2'(np[1]), 2'(np[0])});
  endtask

  // Clock edge: compare registered outputs with the prediction, adopt it.
  task automatic tick();
    logic [17:0] w;
    @(posedge clk);
    #1;
    w = exp_q.pop_front();
    chk("out_val", 32'(bus.out_val), 32'(w[17:15]));
    chk("sel2", 32'(bus.sel2), 32'(w[14:13]));
    chk("sel1", 32'(bus.sel1), 32'(w[12:11]));
    chk("sel0", 32'(bus.sel0), 32'(w[10:9]));
    chk("drop_bad_dest", 32'(bus.drop_bad_dest), 32'(w[8:6]));
    chk("prio", 32'(dbg_prio), 32'(w[5:0]));
    for (int j = 0; j < 3; j++) begin
      m_val[j]  = w[15 + j];
      m_sel[j]  = int'(w[9 + 2*j +: 2]);
      m_prio[j] = int'(w[2*j +: 2]);
    end
  endtask

  // Three requesters on output 1 are served in0, in1, in2 in turn.
  task automatic rr_sweep_out1(input string tag);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk({tag, "_in_rdy"}, 32'(bus.in_rdy), 32'(1 << c));
      tick();
      chk({tag, "_sel1"}, 32'(bus.sel1), 32'(c));
      chk({tag, "_out_val"}, 32'(bus.out_val), 32'h2);
      bus.in_val[c] = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    bus.in_val = '0;
    bus.in_dest0 = '0; bus.in_dest1 = '0; bus.in_dest2 = '0;
    bus.in_domain0 = 1'b0; bus.in_domain1 = 1'b0; bus.in_domain2 = 1'b0;
    bus.out0_domain = 1'b0; bus.out1_domain = 1'b0; bus.out2_domain = 1'b0;
    bus.out_rdy = 3'b111;
    model_reset();

    // Reset state with traffic already offered.
    for (int i = 0; i < 3; i++) set_in(i, 1'b1, 2'd1, 1'b0);
    #2;
    settle();
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'h0);
    tick();
    chk("rst_out_val", 32'(bus.out_val), 32'h0);
    chk("rst_prio", 32'(dbg_prio), 32'h0);
    chk("rst_sel", 32'({bus.sel2, bus.sel1, bus.sel0}), 32'h0);
    chk("rst_drop", 32'(bus.drop_bad_dest), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Round robin on one output straight after reset release.
    rr_sweep_out1("rr");
    settle();
    tick();
    chk("rr_idle_out_val", 32'(bus.out_val), 32'h0);

    // Three inputs to three outputs in parallel.
    set_in(0, 1'b1, 2'd0, 1'b0);
    set_in(1, 1'b1, 2'd1, 1'b0);
    set_in(2, 1'b1, 2'd2, 1'b0);
    settle();
    chk("par_in_rdy", 32'(bus.in_rdy), 32'h7);
    tick();
    chk("par_out_val", 32'(bus.out_val), 32'h7);
    chk("par_sels", 32'({bus.sel2, bus.sel1, bus.sel0}), 32'({2'd2, 2'd1, 2'd0}));
    bus.in_val = '0;

    // Output 2 back-pressured while in1 waits, then drains with no bubble.
    bus.out_rdy = 3'b011;
    set_in(1, 1'b1, 2'd2, 1'b0);
    for (int n = 0; n < 4; n++) begin
      settle();
      chk("bp_in_rdy1", 32'(bus.in_rdy[1]), 32'h0);
      tick();
      chk("bp_sel2", 32'(bus.sel2), 32'h2);
      chk("bp_out_val2", 32'(bus.out_val[2]), 32'h1);
    end
    bus.out_rdy = 3'b111;
    settle();
    chk("drain_in_rdy", 32'(bus.in_rdy), 32'h2);
    tick();
    chk("drain_out_val2", 32'(bus.out_val[2]), 32'h1);
    chk("drain_sel2", 32'(bus.sel2), 32'h1);
    bus.in_val = '0;

    // Invalid destination is consumed and reported for one cycle.
    bus.out_rdy = 3'b000;
    set_in(2, 1'b1, 2'd3, 1'b0);
    settle();
    chk("bad_in_rdy", 32'(bus.in_rdy), 32'h4);
    tick();
    chk("bad_drop", 32'(bus.drop_bad_dest), 32'h4);
    chk("bad_out_val", 32'(bus.out_val), 32'h4);
    bus.in_val = '0;
    settle();
    tick();
    chk("bad_drop_clear", 32'(bus.drop_bad_dest), 32'h0);

    // Domain mismatch: blocked with checking enabled, granted otherwise.
    bus.out_rdy = 3'b111;
    bus.out0_domain = 1'b0;
    set_in(0, 1'b1, 2'd0, 1'b1);
    settle();
    chk("dom_in_rdy0", 32'(bus.in_rdy[0]), DOM_EN ? 32'h0 : 32'h1);
    tick();
    chk("dom_out_val0", 32'(bus.out_val[0]), DOM_EN ? 32'h0 : 32'h1);
    bus.in_val = '0;
    bus.in_domain0 = 1'b0;
    settle();
    tick();

    // Asynchronous reset mid-transfer, then arbitration restarts at in0.
    set_in(1, 1'b1, 2'd1, 1'b0);
    settle();
    tick();
    chk("ar_out_val_pre", 32'(bus.out_val), 32'h2);
    for (int i = 0; i < 3; i++) set_in(i, 1'b1, 2'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_out_val", 32'(bus.out_val), 32'h0);
    chk("ar_prio", 32'(dbg_prio), 32'h0);
    chk("ar_in_rdy", 32'(bus.in_rdy), 32'h0);
    model_reset();
    settle();
    tick();
    @(negedge clk);
    reset = 1'b0;
    rr_sweep_out1("ar");

    // Randomized traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      if (n == 200) begin
        #2;
        reset = 1'b1;
        #1;
        chk("rand_ar_out_val", 32'(bus.out_val), 32'h0);
        model_reset();
        settle();
        tick();
        @(negedge clk);
        reset = 1'b0;
      end
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
